arty_reset_sequencer: RTL and testbench
=======================================

# arty_reset_sequencer

Upstream reset source for the Arty A7 design: it conditions the board reset button, MMCM lock status and a soft-reset request into one clean active-low reset, `o_rstn_seq`. That reset feeds the per-domain reset synchronizers. The block holds reset asserted for a guaranteed minimum time and until the MMCM lock has been stable for a settle interval. It also records the cause of the last reset and counts lock-loss events.

## Interface
- `P_MIN_HOLD_CYCLES`, 256 — minimum cycles spent in HOLD (≥2)
- `P_LOCK_SETTLE_CYCLES`, 1024 — consecutive locked cycles required before release (≥2)
- `P_DEBOUNCE_CYCLES`, 1000000 — cycles the synchronized button must be stable before its debounced state changes (≥2)
- `i_clk_mhz`, in, 1 — board clock; single clock domain
- `i_rstn_global`, in, 1 — asynchronous, active-low reset
- `i_mmcm_locked`, in, 1 — MMCM locked; asynchronous; 2-flop synchronized internally
- `i_btn_rst`, in, 1 — raw pushbutton, active-high; asynchronous; 2-flop synchronized, then debounced
- `i_soft_rst`, in, 1 — synchronous, active-high soft-reset request; single-cycle pulse is sufficient
- `o_rstn_seq`, out, 1 — sequenced reset, active-low, registered; drives the downstream synchronizers
- `o_ready`, out, 1 — high only in RUN, registered
- `o_cause`, out, 2 — cause of last reset: 00 power-on/global, 01 lock loss, 10 button, 11 soft
- `o_lock_loss_count`, out, 8 — lock-loss events from RUN; saturates at 255

## Operation
- **Reset state** (`i_rstn_global` low, asynchronous):
  - FSM is in HOLD; all counters are 0.
  - Synchronizer flops and the debounced button are 0.
  - `o_rstn_seq`=0, `o_ready`=0, `o_cause`=00, `o_lock_loss_count`=0.
- **Debounce:**
  - A counter runs while the synchronized button differs from the debounced state and clears when they match.
  - The debounced state takes the synchronized value on the edge where the counter reaches `P_DEBOUNCE_CYCLES`-1.
- **FSM states:**
  - **HOLD:**
    - The hold counter increments and saturates at `P_MIN_HOLD_CYCLES`-1.
    - Go to WAIT_LOCK when the counter is saturated and the debounced button is 0.
    - A held button keeps the FSM in HOLD indefinitely.
  - **WAIT_LOCK:**
    - Go to SETTLE on the first edge where synchronized lock is 1 and the debounced button is 0.
    - Debounced button = 1 → HOLD.
  - **SETTLE:**
    - The settle counter increments while synchronized lock is 1.
    - Synchronized lock = 0 → WAIT_LOCK with the counter cleared. No cause update and no count increment.
    - Debounced button = 1 → HOLD.
    - Go to RUN on the edge where the counter reaches `P_LOCK_SETTLE_CYCLES`-1.
  - **RUN:**
    - Exit to HOLD on synchronized lock = 0, debounced button = 1, or `i_soft_rst` = 1.
    - Exit priority when events coincide: lock loss > button > soft. Only the highest-priority cause is recorded.
    - Lock loss also increments `o_lock_loss_count` (saturating).
    - The hold and settle counters clear on every entry to HOLD.
- **Outputs:**
  - `o_rstn_seq` and `o_ready` are registered.
  - Both go to 1 on the edge that enters RUN and to 0 on the edge that leaves RUN.
  - `o_cause` updates on the RUN→HOLD edge and holds otherwise.
- **Widths:** each counter is `$clog2` of its parameter; no wrap-around is permitted.

## Timing
- Edge numbering: edge 1 is the first rising edge after `i_rstn_global` deasserts.
- **Startup:**
  - HOLD occupies edges 1..H (H = `P_MIN_HOLD_CYCLES`); WAIT_LOCK is exited on the next edge.
  - With lock already high, `o_rstn_seq` rises at edge H+1+S (S = `P_LOCK_SETTLE_CYCLES`).
- **Lock-loss latency:** when `i_mmcm_locked` falls in RUN, `o_rstn_seq` falls on the 3rd edge (2 synchronizer stages + FSM).
- **Button latency:** when the button is asserted in RUN, `o_rstn_seq` falls on edge 3+D after assertion (D = `P_DEBOUNCE_CYCLES`).
- **Soft-reset latency:** `i_soft_rst` sampled high in RUN → `o_rstn_seq` low on that same edge.
- **Minimum low pulse:** any assertion of `o_rstn_seq` lasts ≥ H+1+S cycles.
- **Mid-operation reset:** `i_rstn_global` asserted in any state forces all reset values immediately, without waiting for a clock; this includes clearing the lock-loss count.

## Test plan
All scenarios use H=4, S=8, D=16.
- **Startup:** lock held high, release `i_rstn_global` → `o_rstn_seq` and `o_ready` rise at edge 13; `o_cause`=00.
- **Lock glitch in SETTLE:** lock drops for 1 cycle at edge 9 → SETTLE restarts; `o_rstn_seq` rises 8 SETTLE cycles after the re-entry to SETTLE; count stays 0.
- **Lock loss in RUN:** drop lock → `o_rstn_seq` low on the 3rd edge; `o_cause`=01; count=1. Repeat 300 times → count=255.
- **Button:** 10-cycle bounce pulses → no reset. Held 40 cycles → `o_rstn_seq` low at edge 19 after press; stays low while held; `o_cause`=10.
- **Simultaneous events:** `i_soft_rst` coincides with the edge where synchronized lock falls → `o_cause`=01 and count increments. Soft reset alone → low on the same edge; `o_cause`=11.
- **Reset mid-SETTLE:** assert `i_rstn_global` → all outputs return to reset values asynchronously; the count clears.

Source files
------------

// File: rtl/arty_reset_sequencer.sv
// rtl/arty_reset_sequencer.sv - board-level reset sequencer: hold, wait for MMCM lock, settle, release
module arty_reset_sequencer #(
    parameter int unsigned P_MIN_HOLD_CYCLES    = 256,
    parameter int unsigned P_LOCK_SETTLE_CYCLES = 1024,
    parameter int unsigned P_DEBOUNCE_CYCLES    = 1000000
) (
    input  logic       i_clk_mhz,
    input  logic       i_rstn_global,
    input  logic       i_mmcm_locked,
    input  logic       i_btn_rst,
    input  logic       i_soft_rst,
    output logic       o_rstn_seq,
    output logic       o_ready,
    output logic [1:0] o_cause,
    output logic [7:0] o_lock_loss_count
);

    localparam int unsigned HOLD_W   = $clog2(P_MIN_HOLD_CYCLES);
    localparam int unsigned SETTLE_W = $clog2(P_LOCK_SETTLE_CYCLES);
    localparam int unsigned DB_W     = $clog2(P_DEBOUNCE_CYCLES);

    localparam logic [HOLD_W-1:0]   HOLD_MAX   = HOLD_W'(P_MIN_HOLD_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(P_LOCK_SETTLE_CYCLES - 1);
    localparam logic [DB_W-1:0]     DB_MAX     = DB_W'(P_DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;
    localparam logic [1:0] CAUSE_SOFT = 2'b11;

    typedef enum logic [1:0] {
        S_HOLD      = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_SETTLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic lock_meta_q, lock_sync_q;
    logic btn_meta_q, btn_sync_q;

    logic            btn_db_q, btn_db_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;

    logic       rstn_q, rstn_d;
    logic       ready_q, ready_d;
    logic [1:0] cause_q, cause_d;
    logic [7:0] loss_cnt_q, loss_cnt_d;

    // Two-flop synchronizers for the asynchronous lock and button inputs
    always_ff @(posedge i_clk_mhz or negedge i_rstn_global) begin
        if (!i_rstn_global) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            btn_meta_q  <= 1'b0;
            btn_sync_q  <= 1'b0;
        end else begin
            lock_meta_q <= i_mmcm_locked;
            lock_sync_q <= lock_meta_q;
            btn_meta_q  <= i_btn_rst;
            btn_sync_q  <= btn_meta_q;
        end
    end

    // Debounce: the button must disagree with the debounced state for a full interval to flip it
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_sync_q != btn_db_q) begin
            if (db_cnt_q == DB_MAX) begin
                btn_db_d = btn_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge i_clk_mhz or negedge i_rstn_global) begin
        if (!i_rstn_global) begin
            btn_db_q <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            btn_db_q <= btn_db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk_mhz or negedge i_rstn_global) begin
        if (!i_rstn_global) begin
            state_q <= S_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; in RUN any exit condition returns to HOLD, cause chosen separately
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == HOLD_MAX && !btn_db_q) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (btn_db_q)         state_d = S_HOLD;
                else if (lock_sync_q) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (btn_db_q)                        state_d = S_HOLD;
                else if (!lock_sync_q)               state_d = S_WAIT_LOCK;
                else if (settle_cnt_q == SETTLE_MAX) state_d = S_RUN;
            end
            S_RUN: begin
                if (!lock_sync_q || btn_db_q || i_soft_rst) state_d = S_HOLD;
            end
            default: state_d = S_HOLD;
        endcase
    end

    // FSM outputs and counters; reset outputs follow the next state so they change on the RUN entry/exit edge
    always_comb begin
        hold_cnt_d   = '0;
        settle_cnt_d = '0;
        rstn_d       = (state_d == S_RUN);
        ready_d      = (state_d == S_RUN);
        cause_d      = cause_q;
        loss_cnt_d   = loss_cnt_q;

        if (state_q == S_HOLD) begin
            hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
        end

        // Counter clears whenever SETTLE is left or re-entered
        if (state_q == S_SETTLE && state_d == S_SETTLE) begin
            settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end

        if (state_q == S_RUN && state_d == S_HOLD) begin
            if (!lock_sync_q) begin
                cause_d = CAUSE_LOCK;
                if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
            end else if (btn_db_q) begin
                cause_d = CAUSE_BTN;
            end else begin
                cause_d = CAUSE_SOFT;
            end
        end
    end

    // Counter and output registers
    always_ff @(posedge i_clk_mhz or negedge i_rstn_global) begin
        if (!i_rstn_global) begin
            hold_cnt_q   <= '0;
            settle_cnt_q <= '0;
            rstn_q       <= 1'b0;
            ready_q      <= 1'b0;
            cause_q      <= 2'b00;
            loss_cnt_q   <= 8'd0;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            rstn_q       <= rstn_d;
            ready_q      <= ready_d;
            cause_q      <= cause_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    assign o_rstn_seq        = rstn_q;
    assign o_ready           = ready_q;
    assign o_cause           = cause_q;
    assign o_lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_arty_reset_sequencer.sv
// tb/tb_arty_reset_sequencer.sv - directed self-checking bench for arty_reset_sequencer
module tb_arty_reset_sequencer;

    logic       clk;
    logic       rstn_global;
    logic       mmcm_locked;
    logic       btn_rst;
    logic       soft_rst;
    logic       rstn_seq;
    logic       ready;
    logic [1:0] cause;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    arty_reset_sequencer #(
        .P_MIN_HOLD_CYCLES   (4),
        .P_LOCK_SETTLE_CYCLES(8),
        .P_DEBOUNCE_CYCLES   (16)
    ) dut (
        .i_clk_mhz        (clk),
        .i_rstn_global    (rstn_global),
        .i_mmcm_locked    (mmcm_locked),
        .i_btn_rst        (btn_rst),
        .i_soft_rst       (soft_rst),
        .o_rstn_seq       (rstn_seq),
        .o_ready          (ready),
        .o_cause          (cause),
        .o_lock_loss_count(loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rstn_global = 1'b0;
        step(2);
        check("rst_rstn", rstn_seq, 0);
        check("rst_ready", ready, 0);
        check("rst_cause", cause, 0);
        check("rst_count", loss_cnt, 0);
        rstn_global = 1'b1;
    endtask

    task automatic wait_run(input string tag);
        for (int i = 0; i < 200 && rstn_seq !== 1'b1; i++) step(1);
        check(tag, rstn_seq, 1);
    endtask

    task automatic lock_loss(input string tag, input int exp_count);
        mmcm_locked = 1'b0;
        step(2);
        check({tag, "_still_up"}, rstn_seq, 1);
        step(1);
        check({tag, "_rstn"}, rstn_seq, 0);
        check({tag, "_cause"}, cause, 1);
        check({tag, "_count"}, loss_cnt, exp_count);
        mmcm_locked = 1'b1;
        wait_run({tag, "_rerun"});
    endtask

    initial begin
        rstn_global = 1'b0;
        mmcm_locked = 1'b1;
        btn_rst     = 1'b0;
        soft_rst    = 1'b0;

        // Startup with lock already high: release at edge 13
        apply_reset();
        step(12);
        check("start_e12_rstn", rstn_seq, 0);
        check("start_e12_ready", ready, 0);
        step(1);
        check("start_e13_rstn", rstn_seq, 1);
        check("start_e13_ready", ready, 1);
        check("start_cause", cause, 0);
        check("start_count", loss_cnt, 0);

        // Lock glitch sampled at edge 9 restarts SETTLE at edge 12, release at edge 20
        apply_reset();
        step(8);
        mmcm_locked = 1'b0;
        step(1);
        mmcm_locked = 1'b1;
        step(4);
        check("glitch_e13_rstn", rstn_seq, 0);
        step(6);
        check("glitch_e19_rstn", rstn_seq, 0);
        step(1);
        check("glitch_e20_rstn", rstn_seq, 1);
        check("glitch_count", loss_cnt, 0);

        // Single lock loss in RUN
        lock_loss("loss1", 1);

        // Soft request lands on the edge where the FSM sees lock low: lock loss wins
        mmcm_locked = 1'b0;
        step(2);
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check("simul_rstn", rstn_seq, 0);
        check("simul_cause", cause, 1);
        check("simul_count", loss_cnt, 2);
        mmcm_locked = 1'b1;
        wait_run("simul_rerun");

        // Soft reset alone drops the reset on the sampling edge
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check("soft_rstn", rstn_seq, 0);
        check("soft_ready", ready, 0);
        check("soft_cause", cause, 3);
        check("soft_count", loss_cnt, 2);
        wait_run("soft_rerun");

        // Bouncing button shorter than the debounce interval does nothing
        for (int p = 0; p < 3; p++) begin
            btn_rst = 1'b1;
            step(10);
            btn_rst = 1'b0;
            step(10);
        end
        step(20);
        check("bounce_rstn", rstn_seq, 1);
        check("bounce_cause", cause, 3);

        // Held button: reset at edge 19 after press, held low while pressed
        btn_rst = 1'b1;
        step(18);
        check("btn_e18_rstn", rstn_seq, 1);
        step(1);
        check("btn_e19_rstn", rstn_seq, 0);
        check("btn_cause", cause, 2);
        step(21);
        check("btn_held_rstn", rstn_seq, 0);
        btn_rst = 1'b0;
        wait_run("btn_rerun");
        check("btn_count", loss_cnt, 2);

        // Many lock losses: count saturates at 255
        for (int n = 3; n <= 300; n++) begin
            lock_loss("loss_rep", (n > 255) ? 255 : n);
        end
        check("sat_count", loss_cnt, 255);

        // Lock loss then asynchronous global reset while in SETTLE
        mmcm_locked = 1'b0;
        step(3);
        mmcm_locked = 1'b1;
        step(7);
        check("mid_rstn_pre", rstn_seq, 0);
        check("mid_count_pre", loss_cnt, 255);
        #2;
        rstn_global = 1'b0;
        #1;
        check("mid_async_rstn", rstn_seq, 0);
        check("mid_async_ready", ready, 0);
        check("mid_async_cause", cause, 0);
        check("mid_async_count", loss_cnt, 0);
        step(1);
        rstn_global = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
